redmule_mx_roundtrip_monitor: RTL and testbench

Synthesizable scoreboard for the FP16 → MXFP8 → FP16 datapath. It taps the FP16 input of the MX encoder and the FP16 output of the MX decoder. Original beats are buffered in a FIFO and compared lane-by-lane against decoded beats under an ULP tolerance. The block accumulates error statistics and emits per-MX-block pass/fail for on-chip BIST and FPGA bring-up. It is purely passive: it never drives the valid/ready signals it observes.

---
 rtl/redmule_mx_roundtrip_monitor_if.sv | 17 +
 rtl/redmule_mx_roundtrip_monitor.sv | 167 ++++++++++++++++
 tb/tb_redmule_mx_roundtrip_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/redmule_mx_roundtrip_monitor_if.sv
// redmule_mx_roundtrip_monitor_if: encoder-input / decoder-output taps of the MX round-trip datapath
// Signals: in_valid/in_ready/in_data   FP16 beat entering the MX encoder
//          out_valid/out_ready/out_data FP16 beat leaving the MX decoder
// master drives the taps (datapath side), slave only observes them (monitor side)
interface redmule_mx_roundtrip_monitor_if #(
   parameter int BITW      = 16,
   parameter int NUM_LANES = 4
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_LANES*BITW-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_LANES*BITW-1:0] out_data;
   modport master (output in_valid, in_ready, in_data, out_valid, out_ready, out_data);
   modport slave  (input  in_valid, in_ready, in_data, out_valid, out_ready, out_data);
endinterface

// File: rtl/redmule_mx_roundtrip_monitor.sv
// redmule_mx_roundtrip_monitor: passive FP16->MXFP8->FP16 scoreboard with ULP-tolerant lane compare
// Ports: clk_i, rst_i (sync, active-high), clear_i (sync clear, same effect as reset)
//        taps         slave view of encoder-input and decoder-output handshakes/data
//        elem_cnt_o   elements compared (wrapping)     err_cnt_o  failing elements (saturating)
//        max_err_o    largest lane error since clear   block_done_o/block_pass_o per-block verdict pulse
//        overflow_o   sticky push-while-full           underflow_o sticky pop-while-empty
module redmule_mx_roundtrip_monitor #(
   parameter int BITW      = 16,
   parameter int NUM_LANES = 4,
   parameter int NUM_ELEMS = 32,
   parameter int DEPTH     = 16,
   parameter int TOL_ULP   = 128
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   redmule_mx_roundtrip_monitor_if.slave taps,
   output logic [31:0]                   elem_cnt_o,
   output logic [15:0]                   err_cnt_o,
   output logic [11:0]                   max_err_o,
   output logic                          block_done_o,
   output logic                          block_pass_o,
   output logic                          overflow_o,
   output logic                          underflow_o
);
   localparam int W     = NUM_LANES * BITW;
   localparam int BEATS = NUM_ELEMS / NUM_LANES;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int NFW   = $clog2(NUM_LANES + 1);

   function automatic logic [11:0] lane_err(input logic [BITW-1:0] a, input logic [BITW-1:0] b);
      logic [4:0]  ea;
      logic [4:0]  eb;
      logic [10:0] big;
      logic [10:0] sml;
      ea = a[14:10];
      eb = b[14:10];
      if (a == b || (a[14:0] == 15'd0 && b[14:0] == 15'd0)) return 12'd0;
      if (ea == 5'd0 || ea == 5'd31 || eb == 5'd0 || eb == 5'd31) return 12'hFFF;
      if (ea == eb) return (a[9:0] > b[9:0]) ? 12'(a[9:0] - b[9:0]) : 12'(b[9:0] - a[9:0]);
      if (ea == eb + 5'd1 || eb == ea + 5'd1) begin
         // the larger-exponent operand is aligned against the other shifted down by one binade
         big = (ea > eb) ? {1'b1, a[9:0]} : {1'b1, b[9:0]};
         sml = ((ea > eb) ? {1'b1, b[9:0]} : {1'b1, a[9:0]}) >> 1;
         return 12'(big - sml);
      end
      return 12'hFFF;
   endfunction

   logic           flush;
   logic           push_req;
   logic           pop_req;
   logic           empty;
   logic           full;
   logic           push;
   logic           pop;
   logic [W-1:0]   mem [DEPTH];
   logic [W-1:0]   head;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   assign flush    = rst_i | clear_i;
   assign push_req = taps.in_valid & taps.in_ready;
   assign pop_req  = taps.out_valid & taps.out_ready;
   assign empty    = count == CW'(0);
   assign full     = count == CW'(DEPTH);
   assign pop      = pop_req & ~empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign push     = push_req & (~full | pop);
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk_i)
      if (push && !flush) mem[wr_ptr] <= taps.in_data;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (push_req && full && !pop) overflow_o <= 1'b1;
         if (pop_req && empty) underflow_o <= 1'b1;
      end
   end

   logic [11:0]          cur_err [NUM_LANES];
   logic [NUM_LANES-1:0] cur_fail;

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         cur_err[l]  = lane_err(head[BITW*l +: BITW], taps.out_data[BITW*l +: BITW]);
         cur_fail[l] = cur_err[l] > 12'(TOL_ULP);
      end
   end

   logic                 s1_valid;
   logic [11:0]          s1_err [NUM_LANES];
   logic [NUM_LANES-1:0] s1_fail;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         s1_valid <= 1'b0;
         s1_fail  <= '0;
         for (int l = 0; l < NUM_LANES; l++) s1_err[l] <= '0;
      end else begin
         s1_valid <= pop;
         if (pop) begin
            s1_fail <= cur_fail;
            for (int l = 0; l < NUM_LANES; l++) s1_err[l] <= cur_err[l];
         end
      end
   end

   logic [11:0]    beat_max;
   logic [NFW-1:0] n_fail;
   logic [16:0]    err_sum;
   logic [BCW-1:0] beat_cnt;
   logic           blk_fail;

   always_comb begin
      beat_max = '0;
      n_fail   = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         beat_max = (s1_err[l] > beat_max) ? s1_err[l] : beat_max;
         n_fail   = n_fail + NFW'(s1_fail[l]);
      end
   end

   assign err_sum = {1'b0, err_cnt_o} + 17'(n_fail);

   always_ff @(posedge clk_i) begin
      if (flush) begin
         elem_cnt_o   <= '0;
         err_cnt_o    <= '0;
         max_err_o    <= '0;
         block_done_o <= 1'b0;
         block_pass_o <= 1'b0;
         beat_cnt     <= '0;
         blk_fail     <= 1'b0;
      end else begin
         block_done_o <= 1'b0;
         block_pass_o <= 1'b0;
         if (s1_valid) begin
            elem_cnt_o <= elem_cnt_o + 32'(NUM_LANES);
            err_cnt_o  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            max_err_o  <= (beat_max > max_err_o) ? beat_max : max_err_o;
            if (beat_cnt == BCW'(BEATS - 1)) begin
               block_done_o <= 1'b1;
               block_pass_o <= ~(blk_fail | (|s1_fail));
               beat_cnt     <= '0;
               blk_fail     <= 1'b0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
               blk_fail <= blk_fail | (|s1_fail);
            end
         end
      end
   end
endmodule

// File: tb/tb_redmule_mx_roundtrip_monitor.sv
// tb_redmule_mx_roundtrip_monitor: directed self-checking bench for the MX round-trip monitor
module tb_redmule_mx_roundtrip_monitor;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        clear_i = 1'b0;
   logic [31:0] elem_cnt_o;
   logic [15:0] err_cnt_o;
   logic [11:0] max_err_o;
   logic        block_done_o;
   logic        block_pass_o;
   logic        overflow_o;
   logic        underflow_o;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          done_cnt = 0;
   int          base;

   redmule_mx_roundtrip_monitor_if #(.BITW(16), .NUM_LANES(4)) taps ();

   redmule_mx_roundtrip_monitor #(
      .BITW(16), .NUM_LANES(4), .NUM_ELEMS(32), .DEPTH(16), .TOL_ULP(128)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .taps(taps),
      .elem_cnt_o(elem_cnt_o), .err_cnt_o(err_cnt_o), .max_err_o(max_err_o),
      .block_done_o(block_done_o), .block_pass_o(block_pass_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (block_done_o) done_cnt++;

   localparam logic [63:0] IDENT = {16'h5000, 16'h4C00, 16'hC000, 16'h4000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input logic [15:0] v);
      return {4{v}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d);
      taps.in_valid = 1'b1;
      taps.in_data  = d;
      tick();
      taps.in_valid = 1'b0;
   endtask

   task automatic pop(input logic [63:0] d);
      taps.out_valid = 1'b1;
      taps.out_data  = d;
      tick();
      taps.out_valid = 1'b0;
   endtask

   task automatic push_pop(input logic [63:0] din, input logic [63:0] dout);
      taps.in_valid  = 1'b1;
      taps.in_data   = din;
      taps.out_valid = 1'b1;
      taps.out_data  = dout;
      tick();
      taps.in_valid  = 1'b0;
      taps.out_valid = 1'b0;
   endtask

   task automatic clr();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " elem"}, elem_cnt_o, 32'd0);
      check({tag, " err"}, 32'(err_cnt_o), 32'd0);
      check({tag, " max"}, 32'(max_err_o), 32'd0);
      check({tag, " done"}, 32'(block_done_o), 32'd0);
      check({tag, " pass"}, 32'(block_pass_o), 32'd0);
      check({tag, " ovf"}, 32'(overflow_o), 32'd0);
      check({tag, " udf"}, 32'(underflow_o), 32'd0);
   endtask

   task automatic restart_block(input string tag);
      base = done_cnt;
      for (int i = 0; i < 8; i++) push(rep(16'h3C00));
      for (int i = 0; i < 7; i++) pop(rep(16'h3C00));
      tick(); tick(); tick();
      check({tag, " no early done"}, 32'(done_cnt - base), 32'd0);
      pop(rep(16'h3C00));
      tick(); tick(); tick();
      check({tag, " one done"}, 32'(done_cnt - base), 32'd1);
      check({tag, " elem"}, elem_cnt_o, 32'd32);
      check({tag, " err"}, 32'(err_cnt_o), 32'd0);
   endtask

   initial begin
      taps.in_valid  = 1'b0;
      taps.in_ready  = 1'b1;
      taps.in_data   = '0;
      taps.out_valid = 1'b0;
      taps.out_ready = 1'b1;
      taps.out_data  = '0;
      tick(); tick();
      rst_i = 1'b0;
      check_zero("reset");

      // identity block
      for (int i = 0; i < 8; i++) push(IDENT);
      for (int i = 0; i < 8; i++) pop(IDENT);
      check("ident done N+1", 32'(block_done_o), 32'd0);
      tick();
      check("ident done N+2", 32'(block_done_o), 32'd1);
      check("ident pass", 32'(block_pass_o), 32'd1);
      check("ident elem", elem_cnt_o, 32'd32);
      check("ident err", 32'(err_cnt_o), 32'd0);
      check("ident max", 32'(max_err_o), 32'd0);
      tick();
      check("ident done pulse", 32'(block_done_o), 32'd0);

      // tolerance boundary: lane0 e=127 pass, lane1 e=129 fail
      clr();
      push({16'h4000, 16'h4000, 16'h4081, 16'h407F});
      for (int i = 0; i < 7; i++) push(rep(16'h4000));
      for (int i = 0; i < 8; i++) pop(rep(16'h4000));
      tick();
      check("tol done", 32'(block_done_o), 32'd1);
      check("tol pass", 32'(block_pass_o), 32'd0);
      check("tol err", 32'(err_cnt_o), 32'd1);
      check("tol max", 32'(max_err_o), 32'd129);
      check("tol elem", elem_cnt_o, 32'd32);

      // exponent cases
      clr();
      push({16'h8000, 16'h4BFF, 16'h8000, 16'h4BFF});
      pop({16'h0000, 16'h4C00, 16'h0000, 16'h4C00});
      tick();
      check("exp adj max", 32'(max_err_o), 32'd1);
      check("exp adj err", 32'(err_cnt_o), 32'd0);
      push(rep(16'h4000));
      pop({16'h5000, 16'h0000, 16'h5000, 16'h0000});
      tick();
      check("exp far max", 32'(max_err_o), 32'd4095);
      check("exp far err", 32'(err_cnt_o), 32'd4);

      // backpressure / overflow
      clr();
      taps.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(rep(16'((i + 1) << 10)));
      check("full no ovf", 32'(overflow_o), 32'd0);
      taps.out_ready = 1'b1;
      push_pop(rep(16'h7400), rep(16'h0400));
      check("full push+pop no ovf", 32'(overflow_o), 32'd0);
      push(rep(16'h7800));
      check("17th push ovf", 32'(overflow_o), 32'd1);
      for (int i = 1; i < 16; i++) pop(rep(16'((i + 1) << 10)));
      pop(rep(16'h7400));
      tick(); tick();
      check("drain err", 32'(err_cnt_o), 32'd0);
      check("drain elem", elem_cnt_o, 32'd68);
      check("drain udf", 32'(underflow_o), 32'd0);

      // underflow with simultaneous push
      push_pop(rep(16'h4400), rep(16'h1234));
      check("udf set", 32'(underflow_o), 32'd1);
      tick(); tick();
      check("udf elem", elem_cnt_o, 32'd68);
      pop(rep(16'h4400));
      tick(); tick();
      check("udf push stored elem", elem_cnt_o, 32'd72);
      check("udf push stored err", 32'(err_cnt_o), 32'd0);

      // mid-block clear
      clr();
      for (int i = 0; i < 8; i++) push(IDENT);
      for (int i = 0; i < 5; i++) pop(IDENT);
      clr();
      check_zero("clear");
      restart_block("clear");

      // mid-block reset
      for (int i = 0; i < 8; i++) push(IDENT);
      for (int i = 0; i < 5; i++) pop(IDENT);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_zero("rst");
      restart_block("rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
